mem_io_responder: RTL and testbench
===================================

Name: mem_io_responder

Overview:
Responder end of the CPU byte-wide memory bus. Serves RAM reads and writes for addresses below 0x30000 and decodes the memory-mapped I/O window where addr[17:16]==2'b11. Owns the UART TX/RX byte FIFOs, the cycle counter, the program-stop flag and the io_buffer_full back-pressure the CPU samples. Sits between the cpu top and the RAM array / UART PHY.

Parameters:
RAM_ADDR_W, 17, RAM byte-address width (128 KiB).
TX_DEPTH, 16, TX FIFO depth in bytes, power of 2, >=4.
RX_DEPTH, 16, RX FIFO depth in bytes, power of 2, >=2.

Ports:
clk_in  in  1  system clock
rst_in  in  1  asynchronous, active-high reset
cpu_a  in  32  byte address from CPU (bits 17:0 decoded)
cpu_wr  in  1  1=write, 0=read, sampled every cycle
cpu_dout  in  8  write data from CPU
cpu_din  out  8  read data to CPU, valid the cycle after the read address
io_buffer_full  out  1  TX FIFO almost full
tx_data  out  8  byte to UART transmitter
tx_valid  out  1  TX FIFO not empty
tx_ready  in  1  UART accepts tx_data this cycle
rx_data  in  8  byte from UART receiver
rx_valid  in  1  push rx_data this cycle
rx_full  out  1  RX FIFO full; rx_valid while high is dropped
program_stop  out  1  sticky, set by a write to 0x30004
tx_overflow  out  1  sticky, a write arrived while the TX FIFO was full

Behaviour:
- Reset (async assert, sync release): cpu_din=0, tx_valid=0, io_buffer_full=0, rx_full=0, program_stop=0, tx_overflow=0, cycle counter=0, FIFOs empty. RAM contents are not reset.
- Bus convention: every cycle is one access. An idle CPU drives cpu_a=0 with cpu_wr=0 (harmless RAM read).
- RAM (addr[17:16]!=2'b11):
  - write: mem[addr[RAM_ADDR_W-1:0]] <= cpu_dout at the clock edge, no wait state.
  - read: cpu_din = mem[addr] one cycle later, synchronous read.
  - read-after-write to the same address in the next cycle returns the new byte.
- IO read 0x30000: pops the RX FIFO head onto cpu_din next cycle. If the RX FIFO is empty, returns 0x00 and the FIFO is unchanged.
- IO read 0x30004..0x30007: cpu_din = byte addr[1:0] of the counter snapshot.
  - A read of 0x30004 loads the snapshot with the live counter and returns byte 0 of the live value.
  - Bytes 1..3 come from the snapshot, so a 4-byte read is coherent.
- IO write 0x30000: pushes cpu_dout into the TX FIFO. Data 0x00 is ignored. Push while full drops the byte and sets tx_overflow.
- IO write 0x30004: sets program_stop and pushes 0x00 into the TX FIFO (subject to the same full rule).
- Other IO addresses: writes ignored, reads return 0x00.
- Cycle counter: 32-bit, +1 per clock, wraps 0xFFFFFFFF->0.
- TX FIFO:
  - tx_data = head byte, tx_valid = !empty. Pop when tx_valid && tx_ready.
  - Simultaneous push and pop when full is allowed; the count is unchanged and no overflow is flagged.
  - io_buffer_full is registered: 1 when count >= TX_DEPTH-2, giving two bytes of slack for the CPU's one-cycle sampling lag.
- RX FIFO:
  - Push when rx_valid && !rx_full. A CPU pop in the same cycle is allowed even when full (count unchanged).
  - rx_full = count==RX_DEPTH.
- Pointers: log2(DEPTH)+1 bits with wrap bit; full when indices match and wrap bits differ.
- Reset mid-operation: in-flight read data is discarded and cpu_din returns to 0.

Decomposition:
- Package mem_io_pkg:
  - IO_BASE=32'h30000, IO_IN_OUT=32'h30000, IO_CLOCK_STOP=32'h30004.
  - function is_io(addr) = addr[17:16]==2'b11.
- Sub-module byte_fifo, parameter DEPTH:
  - push, pop, din, dout, empty, full, count.
  - Instantiated for TX and RX.
- RAM array and IO decode stay inline.

Test Plan:
1. Write 0xA5 to 0x00010, then read 0x00010 next cycle -> cpu_din=0xA5 one cycle after the read; reading 0x00011 (never written) does not disturb it.
2. Writes 0x41, 0x00, 0x42 to 0x30000 with tx_ready=1 -> tx_data sequence 0x41, 0x42 only; tx_overflow stays 0.
3. tx_ready=0, write TX_DEPTH-2 bytes -> io_buffer_full=1 the cycle after the 14th push; 3 more pushes -> FIFO holds 16, tx_overflow=1 on the 17th.
4. At counter=0x00000123, read 0x30004..0x30007 on consecutive cycles -> cpu_din sequence 0x23, 0x01, 0x00, 0x00 despite the live counter advancing.
5. rx_valid pushes 0x55, 0x66; read 0x30000 three times -> 0x55, 0x66, 0x00; with RX full, rx_valid and a CPU pop in the same cycle -> count unchanged.
6. Write 0x30004 then assert rst_in mid-cycle -> program_stop=1 and 0x00 on tx_data before reset; after async reset, all outputs 0 immediately and tx_valid=0.

Source files
------------

// File: rtl/mem_io_pkg.sv
// Shared address map and decode helper for the CPU memory/IO responder.
package mem_io_pkg;

    localparam logic [31:0] IO_BASE       = 32'h0003_0000;
    localparam logic [31:0] IO_IN_OUT     = 32'h0003_0000;
    localparam logic [31:0] IO_CLOCK_STOP = 32'h0003_0004;

    function automatic logic is_io(input logic [31:0] addr);
        return addr[17:16] == 2'b11;
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO with wrap-bit pointers; a push while full is accepted only alongside a pop.
module byte_fifo #(
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               din,
    output logic [7:0]               dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [7:0] mem [DEPTH];
    logic [AW:0] wptr_q, rptr_q;
    logic do_push, do_pop;

    assign empty   = wptr_q == rptr_q;
    assign full    = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
    assign count   = wptr_q - rptr_q;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rptr_q[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + PTR_ONE;
            if (do_pop)  rptr_q <= rptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/mem_io_responder.sv
// Responder for the CPU byte bus: RAM below the IO window, UART FIFOs, cycle counter and stop flag.
module mem_io_responder #(
    parameter int unsigned RAM_ADDR_W = 17,
    parameter int unsigned TX_DEPTH   = 16,
    parameter int unsigned RX_DEPTH   = 16
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] cpu_a,
    input  logic        cpu_wr,
    input  logic [7:0]  cpu_dout,
    output logic [7:0]  cpu_din,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_full,
    output logic        program_stop,
    output logic        tx_overflow
);
    import mem_io_pkg::*;

    localparam int unsigned TXW = $clog2(TX_DEPTH);
    localparam int unsigned RXW = $clog2(RX_DEPTH);
    localparam logic [TXW:0] TX_ALMOST = (TXW + 1)'(TX_DEPTH - 2);
    localparam logic [TXW:0] TX_ZERO   = '0;
    localparam logic [17:0] A_INOUT    = IO_IN_OUT[17:0];
    localparam logic [17:0] A_STOP     = IO_CLOCK_STOP[17:0];

    logic [17:0] a;
    logic        unused_addr;
    logic        io, io_rd, io_wr, ram_we;

    assign a           = cpu_a[17:0];
    assign unused_addr = ^cpu_a[31:18];
    assign io          = is_io(cpu_a);
    assign io_rd       = io && !cpu_wr;
    assign io_wr       = io && cpu_wr;
    assign ram_we      = !io && cpu_wr;

    logic [7:0] ram [2**RAM_ADDR_W];
    logic [7:0] ram_rdata;

    always_ff @(posedge clk_in) begin
        if (ram_we) ram[cpu_a[RAM_ADDR_W-1:0]] <= cpu_dout;
        ram_rdata <= ram[cpu_a[RAM_ADDR_W-1:0]];
    end

    logic         tx_push_req, tx_push_ok, tx_pop, tx_empty, tx_full;
    logic [7:0]   tx_din;
    logic [TXW:0] tx_count, tx_count_nxt;

    assign tx_push_req  = io_wr && ((a == A_INOUT && cpu_dout != 8'h00) || a == A_STOP);
    assign tx_din       = (a == A_STOP) ? 8'h00 : cpu_dout;
    assign tx_valid     = !tx_empty;
    assign tx_pop       = tx_valid && tx_ready;
    assign tx_push_ok   = tx_push_req && (!tx_full || tx_pop);
    assign tx_count_nxt = tx_count + (tx_push_ok ? TX_ZERO + 1'b1 : TX_ZERO)
                                   - (tx_pop ? TX_ZERO + 1'b1 : TX_ZERO);

    byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (clk_in),
        .rst   (rst_in),
        .push  (tx_push_req),
        .pop   (tx_pop),
        .din   (tx_din),
        .dout  (tx_data),
        .empty (tx_empty),
        .full  (tx_full),
        .count (tx_count)
    );

    logic         rx_pop, rx_empty;
    logic [7:0]   rx_head;
    logic [RXW:0] unused_rx_count;

    assign rx_pop = io_rd && a == A_INOUT && !rx_empty;

    // A push while full goes through only when the CPU pops in the same cycle.
    byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk   (clk_in),
        .rst   (rst_in),
        .push  (rx_valid),
        .pop   (rx_pop),
        .din   (rx_data),
        .dout  (rx_head),
        .empty (rx_empty),
        .full  (rx_full),
        .count (unused_rx_count)
    );

    logic [31:0] cycle_q, snap_q;
    logic [7:0]  io_rdata_d, io_rdata_q;
    logic        rd_ram_q, program_stop_q, tx_overflow_q, io_full_q;

    always_comb begin
        io_rdata_d = 8'h00;
        if (io_rd) begin
            case (a)
                A_INOUT:          io_rdata_d = rx_empty ? 8'h00 : rx_head;
                A_STOP:           io_rdata_d = cycle_q[7:0];
                A_STOP + 18'd1:   io_rdata_d = snap_q[15:8];
                A_STOP + 18'd2:   io_rdata_d = snap_q[23:16];
                A_STOP + 18'd3:   io_rdata_d = snap_q[31:24];
                default:          io_rdata_d = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cycle_q        <= '0;
            snap_q         <= '0;
            io_rdata_q     <= '0;
            rd_ram_q       <= 1'b0;
            program_stop_q <= 1'b0;
            tx_overflow_q  <= 1'b0;
            io_full_q      <= 1'b0;
        end else begin
            cycle_q    <= cycle_q + 32'd1;
            io_rdata_q <= io_rdata_d;
            rd_ram_q   <= !io && !cpu_wr;
            io_full_q  <= tx_count_nxt >= TX_ALMOST;
            if (io_rd && a == A_STOP) snap_q <= cycle_q;
            if (io_wr && a == A_STOP) program_stop_q <= 1'b1;
            if (tx_push_req && tx_full && !tx_pop) tx_overflow_q <= 1'b1;
        end
    end

    // rd_ram_q clears on reset, so any in-flight RAM read is hidden behind io_rdata_q == 0.
    assign cpu_din        = rd_ram_q ? ram_rdata : io_rdata_q;
    assign io_buffer_full = io_full_q;
    assign program_stop   = program_stop_q;
    assign tx_overflow    = tx_overflow_q;

endmodule

// File: tb/tb_mem_io_responder.sv
// Randomized directed bench for mem_io_responder against a queue-based reference model.
module tb_mem_io_responder;

    localparam int TX_DEPTH = 16;
    localparam int RX_DEPTH = 16;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [31:0] cpu_a;
    logic        cpu_wr;
    logic [7:0]  cpu_dout;
    logic [7:0]  cpu_din;
    logic        io_buffer_full;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_full;
    logic        program_stop;
    logic        tx_overflow;

    always #5 clk_in = ~clk_in;

    mem_io_responder #(.RAM_ADDR_W(17), .TX_DEPTH(TX_DEPTH), .RX_DEPTH(RX_DEPTH)) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .cpu_a          (cpu_a),
        .cpu_wr         (cpu_wr),
        .cpu_dout       (cpu_dout),
        .cpu_din        (cpu_din),
        .io_buffer_full (io_buffer_full),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_full        (rx_full),
        .program_stop   (program_stop),
        .tx_overflow    (tx_overflow)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    logic [7:0]  ram_m [int];
    logic [7:0]  txq [$];
    logic [7:0]  rxq [$];
    logic [16:0] waddr [$];
    logic [31:0] cnt, snap;
    logic        ps, ovf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        #3 rst_in = 1'b1;
        #1;
        chk("rst_cpu_din", cpu_din, 8'h00);
        chk("rst_tx_valid", tx_valid, 1'b0);
        chk("rst_io_buffer_full", io_buffer_full, 1'b0);
        chk("rst_rx_full", rx_full, 1'b0);
        chk("rst_program_stop", program_stop, 1'b0);
        chk("rst_tx_overflow", tx_overflow, 1'b0);
        txq.delete();
        rxq.delete();
        cnt = 0;
        snap = 0;
        ps = 1'b0;
        ovf = 1'b0;
        @(posedge clk_in);
        @(posedge clk_in);
        #1 rst_in = 1'b0;
    endtask

    // One bus cycle: drive, advance the model, clock, then compare.
    task automatic cycle(input logic [31:0] a, input logic wr, input logic [7:0] d,
                         input logic txr, input logic rxv, input logic [7:0] rxd);
        logic       tpop, rpop, rok, tpush;
        logic [7:0] tval, nd;
        bit         nk;
        cpu_a = a; cpu_wr = wr; cpu_dout = d;
        tx_ready = txr; rx_valid = rxv; rx_data = rxd;
        nk = 0; nd = 8'h00; rpop = 0; tpush = 0; tval = 8'h00;
        tpop = txr && (txq.size() != 0);
        if (a[17:16] != 2'b11) begin
            if (wr) ram_m[int'(a[16:0])] = d;
            else if (ram_m.exists(int'(a[16:0]))) begin
                nk = 1;
                nd = ram_m[int'(a[16:0])];
            end
        end else if (!wr) begin
            nk = 1;
            case (a[17:0])
                18'h30000: if (rxq.size() != 0) begin nd = rxq[0]; rpop = 1; end
                18'h30004: begin nd = cnt[7:0]; snap = cnt; end
                18'h30005: nd = snap[15:8];
                18'h30006: nd = snap[23:16];
                18'h30007: nd = snap[31:24];
                default:   nd = 8'h00;
            endcase
        end else begin
            if (a[17:0] == 18'h30000 && d != 8'h00) begin tpush = 1; tval = d; end
            if (a[17:0] == 18'h30004) begin tpush = 1; tval = 8'h00; ps = 1'b1; end
        end
        if (tpush && txq.size() >= TX_DEPTH && !tpop) ovf = 1'b1;
        if (tpop) void'(txq.pop_front());
        if (tpush && txq.size() < TX_DEPTH) txq.push_back(tval);
        rok = rxv && (rxq.size() < RX_DEPTH || rpop);
        if (rpop) void'(rxq.pop_front());
        if (rok) rxq.push_back(rxd);
        cnt = cnt + 1;
        @(posedge clk_in);
        #1;
        chk("tx_valid", tx_valid, txq.size() != 0);
        if (txq.size() != 0) chk("tx_data", tx_data, txq[0]);
        chk("rx_full", rx_full, rxq.size() == RX_DEPTH);
        chk("io_buffer_full", io_buffer_full, txq.size() >= TX_DEPTH - 2);
        chk("program_stop", program_stop, ps);
        chk("tx_overflow", tx_overflow, ovf);
        if (nk) chk("cpu_din", cpu_din, nd);
    endtask

    task automatic idle(input logic txr);
        cycle(32'h0, 1'b0, 8'h00, txr, 1'b0, 8'h00);
    endtask

    task automatic drain_tx();
        for (int i = 0; i < 40 && txq.size() != 0; i++) idle(1'b1);
    endtask

    initial begin
        logic [16:0] ad;
        logic [7:0]  r;
        int          op;
        rst_in = 1'b0;
        cpu_a = '0; cpu_wr = 1'b0; cpu_dout = '0;
        tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
        cnt = 0; snap = 0; ps = 1'b0; ovf = 1'b0;
        do_reset();

        // RAM write then read-after-write, plus an untouched neighbour
        cycle(32'h10, 1'b1, 8'hA5, 1'b0, 1'b0, 8'h00);
        cycle(32'h10, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        chk("ram_raw_a5", cpu_din, 8'hA5);
        cycle(32'h11, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 30; i++) begin
            ad = 17'($urandom);
            waddr.push_back(ad);
            cycle({15'h0, ad}, 1'b1, 8'($urandom), 1'b0, 1'b0, 8'h00);
        end
        for (int i = 0; i < 30; i++)
            cycle({15'h0, waddr[$urandom_range(0, waddr.size() - 1)]}, 1'b0, 8'h00,
                  1'b0, 1'b0, 8'h00);

        // TX pushes with a zero byte that must be skipped
        cycle(32'h30000, 1'b1, 8'h41, 1'b1, 1'b0, 8'h00);
        chk("tx_first_41", tx_data, 8'h41);
        cycle(32'h30000, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00);
        cycle(32'h30000, 1'b1, 8'h42, 1'b1, 1'b0, 8'h00);
        chk("tx_second_42", tx_data, 8'h42);
        drain_tx();

        // Fill TX past the almost-full mark and into overflow
        for (int i = 0; i < TX_DEPTH + 1; i++)
            cycle(32'h30000, 1'b1, 8'($urandom_range(1, 255)), 1'b0, 1'b0, 8'h00);
        chk("tx_overflow_set", tx_overflow, 1'b1);
        drain_tx();

        // Coherent counter read at 0x123
        do_reset();
        for (int i = 0; i < 400 && cnt != 32'h123; i++) idle(1'b0);
        for (int i = 0; i < 4; i++)
            cycle(32'h30004 + 32'(i), 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        chk("cnt_byte3", cpu_din, 8'h00);

        // RX pushes and pops, including pop past empty
        cycle(32'h0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h55);
        cycle(32'h0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h66);
        cycle(32'h30000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        chk("rx_pop_55", cpu_din, 8'h55);
        cycle(32'h30000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        cycle(32'h30000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        chk("rx_pop_empty", cpu_din, 8'h00);
        for (int i = 0; i < RX_DEPTH; i++)
            cycle(32'h0, 1'b0, 8'h00, 1'b0, 1'b1, 8'($urandom));
        cycle(32'h30000, 1'b0, 8'h00, 1'b0, 1'b1, 8'($urandom));
        cycle(32'h0, 1'b0, 8'h00, 1'b0, 1'b1, 8'($urandom));
        for (int i = 0; i < 4; i++) cycle(32'h30000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);

        // Mixed random traffic
        for (int i = 0; i < 300; i++) begin
            op = int'($urandom_range(0, 7));
            r = 8'($urandom);
            case (op)
                0: begin
                    ad = 17'($urandom);
                    waddr.push_back(ad);
                    cycle({15'h0, ad}, 1'b1, r, 1'($urandom), 1'($urandom), 8'($urandom));
                end
                1: cycle({15'h0, waddr[$urandom_range(0, waddr.size() - 1)]}, 1'b0, 8'h00,
                         1'($urandom), 1'($urandom), 8'($urandom));
                2, 3: cycle(32'h30000, 1'b1, (r[7:5] == 3'b0) ? 8'h00 : r,
                            1'($urandom), 1'($urandom), 8'($urandom));
                4: cycle(32'h30000, 1'b0, 8'h00, 1'($urandom), 1'($urandom), 8'($urandom));
                5: cycle(32'h30004 + 32'($urandom_range(0, 3)), 1'b0, 8'h00,
                         1'($urandom), 1'($urandom), 8'($urandom));
                6: cycle(32'h30008 + 32'($urandom_range(0, 100)), $urandom_range(0, 1) == 1,
                         r, 1'($urandom), 1'($urandom), 8'($urandom));
                default: idle(1'($urandom));
            endcase
        end

        // Stop write then reset with a RAM read in flight
        drain_tx();
        cycle(32'h30004, 1'b1, 8'h77, 1'b0, 1'b0, 8'h00);
        chk("stop_set", program_stop, 1'b1);
        chk("stop_tx_zero", tx_data, 8'h00);
        cpu_a = 32'h10; cpu_wr = 1'b0;
        do_reset();
        for (int i = 0; i < 3; i++) idle(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
